// File: rtl/uart_pkg.sv
// Shared state encodings and parity-mode constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with registered status flags and a one-cycle overflow pulse.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    always_comb begin
        do_pop     = rd_en_i && !empty_q;
        do_push    = wr_en_i && (!full_q || do_pop);
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        empty_d    = (count_d == '0);
        full_d     = (count_d == (AW+1)'(DEPTH));
        overflow_d = wr_en_i && full_q && !do_pop;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small FIFO; frames are sent back-to-back while Start_Flag is high.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        Reset,
    input  logic [DATA_WIDTH-1:0]       Input_Data,
    input  logic                        Load_Data,
    input  logic                        Start_Flag,
    output logic                        Serial_Data,
    output logic [2:0]                  State,
    output logic                        Busy,
    output logic                        Tx_Done,
    output logic                        FIFO_Empty,
    output logic                        FIFO_Full,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_Count,
    output logic                        Overflow
);

    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(STOP_CLKS);
    localparam int BIT_W     = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  line_q, line_d;
    logic                  pop;
    logic                  bit_end, stop_end;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50),
        .rst_i      (Reset),
        .wr_en_i    (Load_Data),
        .wr_data_i  (Input_Data),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_rdata),
        .empty_o    (FIFO_Empty),
        .full_o     (FIFO_Full),
        .count_o    (FIFO_Count),
        .overflow_o (Overflow)
    );

    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_end = (cnt_q == CNT_W'(STOP_CLKS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        line_d  = line_q;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                line_d = 1'b1;
                if (Start_Flag && !FIFO_Empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    par_d   = (^fifo_rdata) ^ (PARITY_MODE == PARITY_ODD);
                    bit_d   = '0;
                    line_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Line is registered, so the next bit is taken from shift_q[1] before shifting.
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (PARITY_MODE != PARITY_NONE) begin
                            line_d  = par_q;
                            state_d = S_PARITY;
                        end else begin
                            line_d  = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    line_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    cnt_d = '0;
                    if (Start_Flag && !FIFO_Empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        par_d   = (^fifo_rdata) ^ (PARITY_MODE == PARITY_ODD);
                        bit_d   = '0;
                        line_d  = 1'b0;
                        state_d = S_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                line_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

    assign Serial_Data = line_q;
    assign State       = state_q;
    assign Busy        = (state_q != S_IDLE);
    assign Tx_Done     = (state_q == S_STOP) && stop_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: an 8N1 instance and a 7E2 instance, both at four clocks per bit.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst;
    logic [7:0] data_a;
    logic       load_a, start_a;
    logic [6:0] data_b;
    logic       load_b, start_b;

    logic       serial_a, busy_a, done_a, empty_a, full_a, ovf_a;
    logic [2:0] state_a, count_a;
    logic       serial_b, busy_b, done_b, empty_b, full_b, ovf_b;
    logic [2:0] state_b, count_b;

    int errors = 0;
    int checks = 0;

    uart_tx_buffered #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (4),
        .PARITY_MODE  (0),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) u_a (
        .CLOCK_50    (clk),
        .Reset       (rst),
        .Input_Data  (data_a),
        .Load_Data   (load_a),
        .Start_Flag  (start_a),
        .Serial_Data (serial_a),
        .State       (state_a),
        .Busy        (busy_a),
        .Tx_Done     (done_a),
        .FIFO_Empty  (empty_a),
        .FIFO_Full   (full_a),
        .FIFO_Count  (count_a),
        .Overflow    (ovf_a)
    );

    uart_tx_buffered #(
        .DATA_WIDTH   (7),
        .CLKS_PER_BIT (4),
        .PARITY_MODE  (1),
        .STOP_BITS    (2),
        .FIFO_DEPTH   (4)
    ) u_b (
        .CLOCK_50    (clk),
        .Reset       (rst),
        .Input_Data  (data_b),
        .Load_Data   (load_b),
        .Start_Flag  (start_b),
        .Serial_Data (serial_b),
        .State       (state_b),
        .Busy        (busy_b),
        .Tx_Done     (done_b),
        .FIFO_Empty  (empty_b),
        .FIFO_Full   (full_b),
        .FIFO_Count  (count_b),
        .Overflow    (ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on cycle 0 of START; returns on cycle 0 of whatever follows the frame.
    task automatic frame_a(input logic [7:0] d);
        int   done_n;
        logic exp_b;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_b = 1'b0;
            else if (i < 36) exp_b = d[(i-4)/4];
            else             exp_b = 1'b1;
            if (i % 4 == 0 || i % 4 == 3)
                chk($sformatf("a_line_%0h_c%0d", d, i), serial_a, exp_b);
            if (i % 4 == 0)
                chk($sformatf("a_state_%0h_c%0d", d, i), state_a, (i == 0) ? 1 : ((i < 36) ? 2 : 4));
            if (i == 0) chk("a_busy", busy_a, 1);
            if (done_a === 1'b1) done_n++;
            if (i == 39) chk($sformatf("a_txdone_last_%0h", d), done_a, 1);
            tick();
        end
        chk($sformatf("a_txdone_once_%0h", d), done_n, 1);
    endtask

    task automatic frame_b(input logic [6:0] d, input logic p);
        int   done_n;
        logic exp_b;
        done_n = 0;
        for (int i = 0; i < 44; i++) begin
            if (i < 4)       exp_b = 1'b0;
            else if (i < 32) exp_b = d[(i-4)/4];
            else if (i < 36) exp_b = p;
            else             exp_b = 1'b1;
            if (i % 4 == 0 || i % 4 == 3)
                chk($sformatf("b_line_%0h_c%0d", d, i), serial_b, exp_b);
            if (i % 4 == 0)
                chk($sformatf("b_state_%0h_c%0d", d, i), state_b,
                    (i == 0) ? 1 : ((i < 32) ? 2 : ((i < 36) ? 3 : 4)));
            if (i == 0) chk("b_busy", busy_b, 1);
            if (done_b === 1'b1) done_n++;
            if (i == 43) chk($sformatf("b_txdone_last_%0h", d), done_b, 1);
            tick();
        end
        chk($sformatf("b_txdone_once_%0h", d), done_n, 1);
    endtask

    initial begin
        rst = 1'b0; load_a = 1'b0; start_a = 1'b0; data_a = '0;
        load_b = 1'b0; start_b = 1'b0; data_b = '0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_state", state_a, 0);
        chk("rst_line", serial_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_b_state", state_b, 0);
        chk("rst_b_line", serial_b, 1);

        load_a = 1'b1; data_a = 8'hAA;
        tick();
        tick();
        chk("rst_load_ignored_count", count_a, 0);
        chk("rst_load_ignored_empty", empty_a, 1);
        rst = 1'b0; load_a = 1'b0;
        tick();

        // Single 0x41 frame, 8N1.
        start_a = 1'b1; load_a = 1'b1; data_a = 8'h41;
        tick();
        chk("load_count", count_a, 1);
        chk("load_empty", empty_a, 0);
        chk("load_state_idle", state_a, 0);
        load_a = 1'b0;
        tick();
        chk("pop_count", count_a, 0);
        frame_a(8'h41);
        chk("after41_state", state_a, 0);
        chk("after41_line", serial_a, 1);
        chk("after41_busy", busy_a, 0);

        // Three queued words, then enable: no idle gap between frames.
        start_a = 1'b0; load_a = 1'b1; data_a = 8'h41;
        tick();
        data_a = 8'h55;
        tick();
        data_a = 8'hFF;
        tick();
        load_a = 1'b0;
        chk("q3_count", count_a, 3);
        chk("q3_state_idle", state_a, 0);
        start_a = 1'b1;
        tick();
        chk("q3_count_after_pop", count_a, 2);
        frame_a(8'h41);
        frame_a(8'h55);
        chk("q3_empty_after_third_pop", empty_a, 1);
        chk("q3_count_after_third_pop", count_a, 0);
        frame_a(8'hFF);
        chk("q3_final_state", state_a, 0);

        // Fill to full and overflow with the transmitter disabled.
        start_a = 1'b0; load_a = 1'b1; data_a = 8'h11;
        tick();
        data_a = 8'h22;
        tick();
        data_a = 8'h33;
        tick();
        data_a = 8'h44;
        tick();
        chk("fill_full", full_a, 1);
        chk("fill_count", count_a, 4);
        chk("fill_no_ovf", ovf_a, 0);
        data_a = 8'h55;
        tick();
        chk("ovf_pulse", ovf_a, 1);
        chk("ovf_count", count_a, 4);
        chk("ovf_full", full_a, 1);
        load_a = 1'b0;
        tick();
        chk("ovf_cleared", ovf_a, 0);
        chk("ovf_count_hold", count_a, 4);

        // Write while full with a simultaneous pop is accepted.
        start_a = 1'b1; load_a = 1'b1; data_a = 8'h66;
        tick();
        load_a = 1'b0;
        chk("wrpop_count", count_a, 4);
        chk("wrpop_full", full_a, 1);
        chk("wrpop_no_ovf", ovf_a, 0);
        frame_a(8'h11);

        // Start_Flag dropped during a frame: it finishes, nothing else is popped.
        start_a = 1'b0;
        frame_a(8'h22);
        chk("stopflag_state", state_a, 0);
        chk("stopflag_count", count_a, 3);
        tick();
        tick();
        chk("stopflag_stay_idle", state_a, 0);

        // Reset in the middle of DATA (cycle 12 = bit 2 of 0x33, a zero).
        start_a = 1'b1;
        tick();
        repeat (12) tick();
        chk("mid_state_data", state_a, 2);
        chk("mid_line_low", serial_a, 0);
        rst = 1'b1;
        #1;
        chk("abort_line", serial_a, 1);
        chk("abort_state", state_a, 0);
        chk("abort_count", count_a, 0);
        chk("abort_empty", empty_a, 1);
        chk("abort_busy", busy_a, 0);
        load_a = 1'b1; data_a = 8'h77;
        tick();
        chk("abort_load_ignored", count_a, 0);

        // First edge after release accepts the write; empty FIFO means no pop that cycle.
        rst = 1'b0; data_a = 8'h5A;
        tick();
        chk("release_count", count_a, 1);
        chk("release_state_idle", state_a, 0);
        load_a = 1'b0;
        tick();
        frame_a(8'h5A);
        chk("release_final_count", count_a, 0);
        start_a = 1'b0;

        // 7 data bits, even parity, 2 stop bits.
        start_b = 1'b1; load_b = 1'b1; data_b = 7'h07;
        tick();
        chk("b_count", count_b, 1);
        chk("b_empty", empty_b, 0);
        chk("b_full", full_b, 0);
        chk("b_ovf", ovf_b, 0);
        load_b = 1'b0;
        tick();
        frame_b(7'h07, 1'b1);
        chk("b_idle_after", state_b, 0);
        load_b = 1'b1; data_b = 7'h03;
        tick();
        load_b = 1'b0;
        tick();
        frame_b(7'h03, 1'b0);
        chk("b_idle_final", state_b, 0);
        chk("b_line_final", serial_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 434: CLOCK_50 cycles per bit (115200 baud), legal >= 2.
REQ-003 Parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: legal 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, >= 2.
REQ-006 CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 Input_Data  input  DATA_WIDTH  word to enqueue.
REQ-009 Load_Data  input  1  single-cycle-qualified write strobe; enqueues Input_Data.
REQ-010 Start_Flag  input  1  level-sensitive transmit enable.
REQ-011 Serial_Data  output  1  UART line, idle high.
REQ-012 State  output  3  current FSM state encoding.
REQ-013 Busy  output  1  high whenever State != IDLE.
REQ-014 Tx_Done  output  1  one-cycle pulse on the last cycle of the final stop bit.
REQ-015 FIFO_Empty / FIFO_Full  output  1 each  FIFO status, registered.
REQ-016 FIFO_Count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-017 Overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE = 0.
REQ-019 In IDLE with Start_Flag = 1 and FIFO_Empty = 0: pop head word into shift register; State = START on the next cycle.
REQ-020 START drives 0 for CLKS_PER_BIT cycles; DATA drives DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles.
REQ-021 PARITY drives XOR of data bits (even) or its inverse (odd) for CLKS_PER_BIT cycles.
REQ-022 STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 Serial_Data is registered; it changes only on bit boundaries; 1 in IDLE.
REQ-024 Load_Data at edge N: FIFO_Count increments and FIFO_Empty clears at N+1; with Start_Flag high and IDLE, START at N+2.
REQ-025 Back-to-back: at the last STOP cycle, if Start_Flag = 1 and FIFO non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
REQ-026 Start_Flag falling mid-frame: current frame completes; no further pop.
REQ-027 Write when full without simultaneous pop: word dropped, FIFO unchanged, Overflow pulses.
REQ-028 Write when full with simultaneous pop: write accepted, FIFO_Count unchanged.
REQ-029 Write and pop while empty: write stored; no pop occurs that cycle.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH; FIFO_Count never exceeds FIFO_DEPTH.
REQ-031 Bit-period counter resets to 0 on every bit boundary and on every state entry.

Reset
REQ-032 Reset asserted: State = IDLE, Serial_Data = 1, Busy = 0, Tx_Done = 0, Overflow = 0, FIFO cleared (Count 0, Empty 1, Full 0), counters 0, with no clock edge required.
REQ-033 Reset mid-frame aborts the frame; line returns high immediately; queued words are discarded.
REQ-034 Load_Data during Reset is ignored; first accepted write is on the first edge after release.

Structure
REQ-035 Package uart_pkg holds the state encodings (IDLE 0, START 1, DATA 2, PARITY 3, STOP 4) and PARITY_MODE constants.
REQ-036 The FIFO is a sub-module, uart_tx_fifo, parametrised by width and depth; the FSM, shifter and baud counter stay in the top.
REQ-037 No latches; all registers share the same async-reset structure.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-038 0x41, 8N1, Start_Flag high: line 0,1,0,0,0,0,0,1,0,1, each 4 cycles; Tx_Done once; 40 cycles START..STOP end.
REQ-039 Push 0x41, 0x55, 0xFF, then raise Start_Flag: three frames with no idle gap; FIFO_Empty set after third pop.
REQ-040 DATA_WIDTH 7, even parity, 2 stop bits, 0x07: parity bit 1, stop high 8 cycles; 11-bit frame.
REQ-041 FIFO_DEPTH 4, Start_Flag low, 5 writes: FIFO_Full after 4; fifth raises Overflow; Count 4.
REQ-042 Reset asserted mid DATA: Serial_Data 1 and State IDLE before next edge; FIFO_Count 0.
REQ-043 Drop Start_Flag during frame 1 of 2 queued: frame 1 completes; frame 2 stays queued; Count 1.
